// File: rtl/hfosc_wake_seq_pkg.sv
// Shared definitions for the HF oscillator wake sequencer: state encoding,
// wake counter width and the dwell-counter width helper.
package hfosc_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWRUP   = 3'd1,
    ST_ENWAIT  = 3'd2,
    ST_ON      = 3'd3,
    ST_DISABLE = 3'd4,
    ST_PWRDN   = 3'd5
  } hfosc_state_e;

  localparam int WAKE_COUNT_W = 16;

  // Width needed to hold (largest dwell - 1); never less than one bit.
  function automatic int dwell_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hfosc_wake_seq_sync_ff.sv
// Multi-flop level synchronizer for a single asynchronous control bit.
// Resets to 0 so a request is never seen as active straight out of reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the async level through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hfosc_wake_seq.sv
// HF oscillator wake sequencer. Runs on the always-on slow clock, follows
// the PMU clock request and drives the oscillator power-up / enable pins in
// order, then raises clk_ready once the fast clock has had time to settle.
// Every output is a flop loaded from the next-state decode, so the
// oscillator pins cannot glitch.
module hfosc_wake_seq
  import hfosc_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 2,
  parameter int ENABLE_CYCLES   = 1,
  parameter int OFF_HOLD_CYCLES = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    slow_clk,
  input  logic                    rst,
  input  logic                    hf_req,
  output logic                    clkhf_powerup,
  output logic                    clkhf_enable,
  output logic                    clk_ready,
  output logic                    seq_busy,
  output logic [2:0]              seq_state,
  output logic [WAKE_COUNT_W-1:0] wake_count
);

  localparam int CNT_W = dwell_cnt_w(SETTLE_CYCLES, ENABLE_CYCLES, OFF_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENABLE_LD = CNT_W'(ENABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFFH_LD   = CNT_W'(OFF_HOLD_CYCLES - 1);

  // Saturating increment for the wake counter: holds at all-ones.
  function automatic logic [WAKE_COUNT_W-1:0] sat_inc(input logic [WAKE_COUNT_W-1:0] v);
    return (v == '1) ? v : v + WAKE_COUNT_W'(1);
  endfunction

  logic                    req_s;
  hfosc_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WAKE_COUNT_W-1:0] wake_q, wake_d;
  logic                    pu_q, pu_d;
  logic                    en_q, en_d;
  logic                    rdy_q, rdy_d;
  logic                    busy_q, busy_d;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk (slow_clk),
    .rst (rst),
    .d_i (hf_req),
    .q_o (req_s)
  );

  // Next-state, dwell counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wake_d  = wake_q;

    case (state_q)
      ST_OFF: begin
        if (req_s) begin
          state_d = ST_PWRUP;
          cnt_d   = SETTLE_LD;
        end
      end
      ST_PWRUP: begin
        if (!req_s) begin
          state_d = ST_PWRDN;
          cnt_d   = OFFH_LD;
        end else if (cnt_q == '0) begin
          state_d = ST_ENWAIT;
          cnt_d   = ENABLE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ENWAIT: begin
        if (!req_s) begin
          state_d = ST_DISABLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_ON;
          cnt_d   = '0;
          wake_d  = sat_inc(wake_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ON: begin
        if (!req_s) begin
          state_d = ST_DISABLE;
          cnt_d   = '0;
        end
      end
      ST_DISABLE: begin
        // Enable has already dropped; hold power for this one cycle.
        state_d = ST_PWRDN;
        cnt_d   = OFFH_LD;
      end
      ST_PWRDN: begin
        if (cnt_q == '0) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    pu_d   = 1'b0;
    en_d   = 1'b0;
    rdy_d  = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      ST_PWRUP: begin
        pu_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_ENWAIT: begin
        pu_d   = 1'b1;
        en_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_ON: begin
        pu_d  = 1'b1;
        en_d  = 1'b1;
        rdy_d = 1'b1;
      end
      ST_DISABLE: begin
        pu_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_PWRDN: begin
        busy_d = 1'b1;
      end
      default: begin
        pu_d = 1'b0;
      end
    endcase
  end

  // State, counters and output flops; reset drops everything at once.
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      wake_q  <= '0;
      pu_q    <= 1'b0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wake_q  <= wake_d;
      pu_q    <= pu_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign clkhf_powerup = pu_q;
  assign clkhf_enable  = en_q;
  assign clk_ready     = rdy_q;
  assign seq_busy      = busy_q;
  assign seq_state     = state_q;
  assign wake_count    = wake_q;

endmodule

// File: tb/tb_hfosc_wake_seq.sv
// Bench for hfosc_wake_seq: a cycle model of the wake sequence feeds a
// scoreboard queue, plus directed checks on latency and boundary cases.
`timescale 1ns/1ps
module tb_hfosc_wake_seq;

  localparam int SETTLE   = 2;
  localparam int ENABLE   = 1;
  localparam int OFF_HOLD = 2;
  localparam int SYNC     = 2;

  localparam int S_OFF = 0, S_PWRUP = 1, S_ENWAIT = 2, S_ON = 3, S_DISABLE = 4, S_PWRDN = 5;

  typedef struct packed {
    logic        pu;
    logic        en;
    logic        rdy;
    logic        busy;
    logic [2:0]  st;
    logic [15:0] wc;
  } exp_t;

  logic        slow_clk;
  logic        rst;
  logic        hf_req;
  logic        clkhf_powerup;
  logic        clkhf_enable;
  logic        clk_ready;
  logic        seq_busy;
  logic [2:0]  seq_state;
  logic [15:0] wake_count;

  int          total;
  int          bad;
  exp_t        sb_q[$];

  int               m_st;
  int               m_el;
  logic [15:0]      m_wc;
  logic [SYNC-1:0]  m_sync;
  logic             sat_load;
  logic             prev_pu;
  logic             prev_en;

  hfosc_wake_seq #(
    .SETTLE_CYCLES  (SETTLE),
    .ENABLE_CYCLES  (ENABLE),
    .OFF_HOLD_CYCLES(OFF_HOLD),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .slow_clk     (slow_clk),
    .rst          (rst),
    .hf_req       (hf_req),
    .clkhf_powerup(clkhf_powerup),
    .clkhf_enable (clkhf_enable),
    .clk_ready    (clk_ready),
    .seq_busy     (seq_busy),
    .seq_state    (seq_state),
    .wake_count   (wake_count)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One slow_clk edge of the reference sequence, sampling rst/hf_req.
  task automatic model_step();
    logic rs;
    if (rst) begin
      m_sync = '0;
      m_st   = S_OFF;
      m_el   = 0;
      m_wc   = '0;
      return;
    end
    if (sat_load) m_wc = 16'hFFFE;
    rs     = m_sync[SYNC-1];
    m_sync = {m_sync[SYNC-2:0], hf_req};
    case (m_st)
      S_OFF:     if (rs) begin m_st = S_PWRUP; m_el = 0; end
      S_PWRUP: begin
        if (!rs) begin m_st = S_PWRDN; m_el = 0; end
        else if (m_el >= SETTLE - 1) begin m_st = S_ENWAIT; m_el = 0; end
        else m_el++;
      end
      S_ENWAIT: begin
        if (!rs) begin m_st = S_DISABLE; m_el = 0; end
        else if (m_el >= ENABLE - 1) begin
          m_st = S_ON;
          m_el = 0;
          if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
        end else m_el++;
      end
      S_ON:      if (!rs) begin m_st = S_DISABLE; m_el = 0; end
      S_DISABLE: begin m_st = S_PWRDN; m_el = 0; end
      S_PWRDN: begin
        if (m_el >= OFF_HOLD - 1) begin m_st = S_OFF; m_el = 0; end
        else m_el++;
      end
      default:   m_st = S_OFF;
    endcase
  endtask

  // Advance one clock: model pushes at the edge, DUT compared half a cycle later.
  task automatic tick();
    exp_t e;
    logic rst_at_edge;
    prev_pu = clkhf_powerup;
    prev_en = clkhf_enable;
    @(posedge slow_clk);
    rst_at_edge = rst;
    model_step();
    e.pu   = (m_st == S_PWRUP) || (m_st == S_ENWAIT) || (m_st == S_ON) || (m_st == S_DISABLE);
    e.en   = (m_st == S_ENWAIT) || (m_st == S_ON);
    e.rdy  = (m_st == S_ON);
    e.busy = (m_st == S_PWRUP) || (m_st == S_ENWAIT) || (m_st == S_DISABLE) || (m_st == S_PWRDN);
    e.st   = 3'(m_st);
    e.wc   = m_wc;
    sb_q.push_back(e);
    @(negedge slow_clk);
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(0), 32'(1));
    end else begin
      e = sb_q.pop_front();
      check_val("sb_pu",   32'(clkhf_powerup), 32'(e.pu));
      check_val("sb_en",   32'(clkhf_enable),  32'(e.en));
      check_val("sb_rdy",  32'(clk_ready),     32'(e.rdy));
      check_val("sb_busy", 32'(seq_busy),      32'(e.busy));
      check_val("sb_st",   32'(seq_state),     32'(e.st));
      check_val("sb_wc",   32'(wake_count),    32'(e.wc));
    end
    check_val("inv_en_pu",  32'(clkhf_enable & ~clkhf_powerup), 32'(0));
    check_val("inv_rdy_en", 32'(clk_ready & ~clkhf_enable),     32'(0));
    if (prev_pu && !clkhf_powerup && !rst_at_edge)
      check_val("inv_en_before_pu", 32'(prev_en), 32'(0));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int  low_cnt;
    bit  saw_off;
    bit  saw_pwrup;
    bit  saw_pwrdn;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    hf_req   = 1'b0;
    sat_load = 1'b0;
    m_st     = S_OFF;
    m_el     = 0;
    m_wc     = '0;
    m_sync   = '0;
    prev_pu  = 1'b0;
    prev_en  = 1'b0;

    // Reset state
    ticks(3);
    check_val("rst_pu",   32'(clkhf_powerup), 32'(0));
    check_val("rst_en",   32'(clkhf_enable),  32'(0));
    check_val("rst_rdy",  32'(clk_ready),     32'(0));
    check_val("rst_busy", 32'(seq_busy),      32'(0));
    check_val("rst_st",   32'(seq_state),     32'(0));
    check_val("rst_wc",   32'(wake_count),    32'(0));
    rst = 1'b0;
    ticks(2);

    // Wake latency from request
    hf_req = 1'b1;
    tick(); check_val("e1_pu", 32'(clkhf_powerup), 32'(0));
    tick(); check_val("e2_pu", 32'(clkhf_powerup), 32'(0));
    check_val("e2_busy", 32'(seq_busy), 32'(0));
    tick(); check_val("e3_pu", 32'(clkhf_powerup), 32'(1));
    check_val("e3_busy", 32'(seq_busy), 32'(1));
    check_val("e3_st", 32'(seq_state), 32'(S_PWRUP));
    tick(); check_val("e4_en", 32'(clkhf_enable), 32'(0));
    tick(); check_val("e5_en", 32'(clkhf_enable), 32'(1));
    check_val("e5_rdy", 32'(clk_ready), 32'(0));
    tick(); check_val("e6_rdy", 32'(clk_ready), 32'(1));
    check_val("e6_busy", 32'(seq_busy), 32'(0));
    check_val("e6_wc", 32'(wake_count), 32'(1));

    // Orderly shutdown from ON
    hf_req = 1'b0;
    ticks(2); check_val("dn2_rdy", 32'(clk_ready), 32'(1));
    tick();   check_val("dn3_st", 32'(seq_state), 32'(S_DISABLE));
    check_val("dn3_en", 32'(clkhf_enable), 32'(0));
    check_val("dn3_pu", 32'(clkhf_powerup), 32'(1));
    tick();   check_val("dn4_pu", 32'(clkhf_powerup), 32'(0));
    check_val("dn4_st", 32'(seq_state), 32'(S_PWRDN));
    tick();   check_val("dn5_st", 32'(seq_state), 32'(S_PWRDN));
    tick();   check_val("dn6_st", 32'(seq_state), 32'(S_OFF));

    // Short request aborts out of PWRUP
    hf_req = 1'b1;
    ticks(2);
    hf_req = 1'b0;
    saw_pwrup = 0;
    saw_pwrdn = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("abort_en", 32'(clkhf_enable), 32'(0));
      if (seq_state == 3'(S_PWRUP)) saw_pwrup = 1;
      if (seq_state == 3'(S_PWRDN)) saw_pwrdn = 1;
    end
    check_val("abort_path", 32'({saw_pwrup, saw_pwrdn}), 32'(3));
    check_val("abort_st", 32'(seq_state), 32'(S_OFF));
    check_val("abort_wc", 32'(wake_count), 32'(1));

    // Request re-asserted during PWRDN waits for OFF
    hf_req = 1'b1;
    ticks(6);
    check_val("rearm_on", 32'(clk_ready), 32'(1));
    hf_req = 1'b0;
    ticks(4);
    check_val("rearm_pd", 32'(seq_state), 32'(S_PWRDN));
    hf_req  = 1'b1;
    low_cnt = 1;
    saw_off = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (seq_state == 3'(S_OFF)) saw_off = 1;
      if (clkhf_powerup) break;
      low_cnt++;
    end
    check_val("rearm_pu", 32'(clkhf_powerup), 32'(1));
    check_val("rearm_low", 32'(low_cnt), 32'(3));
    check_val("rearm_off", 32'(saw_off), 32'(1));
    ticks(3);
    check_val("rearm_rdy", 32'(clk_ready), 32'(1));
    check_val("rearm_wc", 32'(wake_count), 32'(3));

    // Reset in the middle of ENWAIT
    hf_req = 1'b0;
    ticks(6);
    hf_req = 1'b1;
    ticks(5);
    check_val("mid_st", 32'(seq_state), 32'(S_ENWAIT));
    rst = 1'b1;
    tick();
    check_val("mid_rst_pu", 32'(clkhf_powerup), 32'(0));
    check_val("mid_rst_en", 32'(clkhf_enable),  32'(0));
    check_val("mid_rst_st", 32'(seq_state),     32'(S_OFF));
    check_val("mid_rst_wc", 32'(wake_count),    32'(0));
    rst = 1'b0;
    ticks(2); check_val("rel_pu2", 32'(clkhf_powerup), 32'(0));
    tick();   check_val("rel_pu3", 32'(clkhf_powerup), 32'(1));
    ticks(3); check_val("rel_rdy", 32'(clk_ready), 32'(1));
    check_val("rel_wc", 32'(wake_count), 32'(1));

    // Wake counter saturation
    hf_req = 1'b0;
    ticks(6);
    check_val("sat_off", 32'(seq_state), 32'(S_OFF));
    #1;
    force dut.wake_q = 16'hFFFE;
    sat_load = 1'b1;
    tick();
    sat_load = 1'b0;
    release dut.wake_q;
    hf_req = 1'b1;
    ticks(6);
    check_val("sat_ffff", 32'(wake_count), 32'hFFFF);
    hf_req = 1'b0;
    ticks(6);
    hf_req = 1'b1;
    ticks(6);
    check_val("sat_hold", 32'(wake_count), 32'hFFFF);
    check_val("sat_on", 32'(seq_state), 32'(S_ON));
    hf_req = 1'b0;
    ticks(6);

    // Glitches narrower than a clock period
    #1 hf_req = 1'b1;
    #2 hf_req = 1'b0;
    ticks(3);
    check_val("glitch_miss", 32'(clkhf_powerup), 32'(0));
    #3 hf_req = 1'b1;
    fork
      begin
        #4 hf_req = 1'b0;
      end
    join_none
    ticks(10);
    check_val("glitch_st", 32'(seq_state), 32'(S_OFF));
    check_val("glitch_wc", 32'(wake_count), 32'hFFFF);
    check_val("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
